// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: FSM state encoding,
// ALU opcodes and datapath width.
package alu_arbiter_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU (a, b, aluc -> result, zero).
// Opcodes with no defined operation produce a zero result and raise no error.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        aluc,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    casez (aluc)
      4'b?000: result = a + b;
      4'b?100: result = a - b;
      4'b?001: result = a & b;
      4'b?101: result = a | b;
      4'b?010: result = a ^ b;
      4'b?110: result = {b[15:0], 16'h0000};
      4'b0011: result = b << a[4:0];
      4'b0111: result = b >> a[4:0];
      4'b1111: result = $unsigned($signed(b) >>> a[4:0]);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU: IDLE/EXEC/RESP FSM, one operation
// per 3 cycles, round-robin (RR_EN=1) or fixed priority to requester 0.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  input  logic [3:0]        aluc0,
  input  logic [3:0]        aluc1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              busy
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              owner;
  logic              last_gnt;
  logic              pick1;
  logic              any_req;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [3:0]        aluc_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero_unused;

  assign any_req = req0 | req1;

  // last_gnt holds the most recently granted requester; under contention the other one wins.
  always_comb begin
    pick1 = req1;
    if (req0 && req1) begin
      pick1 = (RR_EN != 0) ? ~last_gnt : 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      aluc_q   <= '0;
      result_o <= '0;
      zero_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && any_req) begin
        owner    <= pick1;
        last_gnt <= pick1;
        a_q      <= pick1 ? a1 : a0;
        b_q      <= pick1 ? b1 : b0;
        aluc_q   <= pick1 ? aluc1 : aluc0;
      end
      if (state == ST_EXEC) begin
        result_o <= alu_res;
        zero_o   <= (alu_res == '0);
      end
    end
  end

  // The ALU only ever sees the captured operands, never the live request inputs.
  alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .aluc   (aluc_q),
    .result (alu_res),
    .zero   (alu_zero_unused)
  );

  assign gnt0  = (state == ST_EXEC) && !owner;
  assign gnt1  = (state == ST_EXEC) &&  owner;
  assign done0 = (state == ST_RESP) && !owner;
  assign done1 = (state == ST_RESP) &&  owner;
  assign busy  = (state == ST_EXEC) || (state == ST_RESP);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level arbitration/ALU model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [3:0]  aluc0 = '0, aluc1 = '0;
  logic        gnt0, gnt1, done0, done1, zero_o, busy;
  logic [31:0] result_o;
  logic        gnt0_f, gnt1_f, done0_f, done1_f, zero_f, busy_f;
  logic [31:0] result_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .clrn(clrn), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .aluc0(aluc0), .aluc1(aluc1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result_o(result_o), .zero_o(zero_o), .busy(busy)
  );

  alu_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .clrn(clrn), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .aluc0(aluc0), .aluc1(aluc1),
    .gnt0(gnt0_f), .gnt1(gnt1_f), .done0(done0_f), .done1(done1_f),
    .result_o(result_f), .zero_o(zero_f), .busy(busy_f)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU written from the opcode table.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    logic [4:0] sh;
    sh = a[4:0];
    if (op[2:0] == 3'b000) return a + b;
    if (op[2:0] == 3'b100) return a - b;
    if (op[2:0] == 3'b001) return a & b;
    if (op[2:0] == 3'b101) return a | b;
    if (op[2:0] == 3'b010) return a ^ b;
    if (op[2:0] == 3'b110) return b * 32'd65536;
    if (op == 4'b0011) return b << sh;
    if (op == 4'b0111) return b >> sh;
    if (op == 4'b1111) return (b[31] ? ~((~b) >> sh) : (b >> sh));
    return 32'd0;
  endfunction

  task automatic apply_reset();
    clrn = 1'b0; req0 = 1'b0; req1 = 1'b0;
    step();
    clrn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clrn = 1'b0; req0 = 1'b1; req1 = 1'b1;
    repeat (2) step();
    checks++; if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got %b want 0000", {gnt0, gnt1, done0, done1}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (result_o !== 32'd0) begin errors++; $display("FAIL reset_result got %0d want 0", result_o); end
    checks++; if (zero_o !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", zero_o); end
    req0 = 1'b0; req1 = 1'b0;
    clrn = 1'b1;
    step();
  endtask

  task automatic test_add();
    req0 = 1'b1; a0 = 32'd127; b0 = 32'd128; aluc0 = ALUC_ADD;
    step();
    checks++; if ({gnt1, gnt0} !== 2'b01) begin errors++; $display("FAIL add_gnt got %b want 01", {gnt1, gnt0}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy_exec got %b want 1", busy); end
    req0 = 1'b0;
    step();
    checks++; if ({done1, done0} !== 2'b01) begin errors++; $display("FAIL add_done got %b want 01", {done1, done0}); end
    checks++; if (result_o !== 32'd255 || zero_o !== 1'b0) begin errors++; $display("FAIL add_result got %0d/%b want 255/0", result_o, zero_o); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy_resp got %b want 1", busy); end
    step();
    checks++; if (busy !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL add_idle busy/done got %b%b want 00", busy, done0); end
    checks++; if (result_o !== 32'd255) begin errors++; $display("FAIL add_hold got %0d want 255", result_o); end
  endtask

  task automatic test_sub();
    req1 = 1'b1; a1 = 32'd128; b1 = 32'd128; aluc1 = ALUC_SUB;
    step();
    checks++; if ({gnt1, gnt0} !== 2'b10) begin errors++; $display("FAIL sub_gnt got %b want 10", {gnt1, gnt0}); end
    req1 = 1'b0;
    step();
    checks++; if ({done1, done0} !== 2'b10) begin errors++; $display("FAIL sub_done got %b want 10", {done1, done0}); end
    checks++; if (result_o !== 32'd0 || zero_o !== 1'b1) begin errors++; $display("FAIL sub_result got %0d/%b want 0/1", result_o, zero_o); end
    step();
  endtask

  task automatic test_simultaneous();
    int t_done0;
    int t_done1;
    t_done0 = -1; t_done1 = -1;
    apply_reset();
    req0 = 1'b1; a0 = 32'd1; b0 = 32'd1; aluc0 = ALUC_ADD;
    req1 = 1'b1; a1 = 32'd5; b1 = 32'd3; aluc1 = ALUC_SUB;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
      if (done0) begin
        t_done0 = c;
        checks++; if (result_o !== 32'd2) begin errors++; $display("FAIL simul_res0 got %0d want 2", result_o); end
      end
      if (done1) begin
        t_done1 = c;
        checks++; if (result_o !== 32'd2) begin errors++; $display("FAIL simul_res1 got %0d want 2", result_o); end
      end
    end
    checks++; if (t_done0 !== 2) begin errors++; $display("FAIL simul_done0_cycle got %0d want 2", t_done0); end
    checks++; if (t_done1 !== 5) begin errors++; $display("FAIL simul_done1_cycle got %0d want 5", t_done1); end
  endtask

  task automatic test_round_robin();
    logic seq_rr [8];
    logic seq_fp [8];
    int n_rr;
    int n_fp;
    n_rr = 0; n_fp = 0;
    apply_reset();
    req0 = 1'b1; a0 = 32'd3; b0 = 32'd4; aluc0 = ALUC_ADD;
    req1 = 1'b1; a1 = 32'd9; b1 = 32'd2; aluc1 = ALUC_SUB;
    for (int c = 0; c < 12; c++) begin
      if (c == 11) begin req0 = 1'b0; req1 = 1'b0; end
      step();
      checks++; if (gnt0 && gnt1) begin errors++; $display("FAIL rr_onehot both gnt at cycle %0d", c); end
      if ((gnt0 || gnt1) && n_rr < 8) begin seq_rr[n_rr] = gnt1; n_rr++; end
      if ((gnt0_f || gnt1_f) && n_fp < 8) begin seq_fp[n_fp] = gnt1_f; n_fp++; end
    end
    checks++; if (n_rr !== 4) begin errors++; $display("FAIL rr_count got %0d want 4", n_rr); end
    checks++; if (n_fp !== 4) begin errors++; $display("FAIL fp_count got %0d want 4", n_fp); end
    for (int i = 0; i < 4 && i < n_rr; i++) begin
      checks++; if (seq_rr[i] !== i[0]) begin errors++; $display("FAIL rr_order[%0d] got %0d want %0d", i, seq_rr[i], i[0]); end
    end
    for (int i = 0; i < 4 && i < n_fp; i++) begin
      checks++; if (seq_fp[i] !== 1'b0) begin errors++; $display("FAIL fp_order[%0d] got %0d want 0", i, seq_fp[i]); end
    end
    step();
  endtask

  task automatic test_reset_exec();
    req0 = 1'b1; a0 = 32'd7; b0 = 32'd8; aluc0 = ALUC_ADD;
    step();
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rst_exec_gnt got %b want 1", gnt0); end
    clrn = 1'b0; req0 = 1'b0;
    #1;
    checks++; if ({gnt0, gnt1, done0, done1, busy, zero_o} !== 6'b0 || result_o !== 32'd0) begin
      errors++; $display("FAIL rst_exec_outputs got %b/%0d want 000000/0", {gnt0, gnt1, done0, done1, busy, zero_o}, result_o);
    end
    step();
    checks++; if ({done0, done1} !== 2'b00) begin errors++; $display("FAIL rst_exec_nodone got %b want 00", {done0, done1}); end
    clrn = 1'b1;
    step();
    req1 = 1'b1; a1 = 32'd2; b1 = 32'd2; aluc1 = ALUC_ADD;
    step();
    checks++; if ({gnt1, gnt0} !== 2'b10) begin errors++; $display("FAIL rst_after_gnt got %b want 10", {gnt1, gnt0}); end
    req1 = 1'b0;
    step();
    checks++; if (done1 !== 1'b1 || result_o !== 32'd4 || zero_o !== 1'b0) begin
      errors++; $display("FAIL rst_after_done got %b/%0d/%b want 1/4/0", done1, result_o, zero_o);
    end
    step();
  endtask

  task automatic test_hold();
    req0 = 1'b1; a0 = 32'd10; b0 = 32'd20; aluc0 = ALUC_ADD;
    step();
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL hold_gnt_first got %b want 1", gnt0); end
    step();
    checks++; if (done0 !== 1'b1 || result_o !== 32'd30) begin errors++; $display("FAIL hold_done_first got %b/%0d want 1/30", done0, result_o); end
    step();
    checks++; if ({gnt0, busy} !== 2'b00) begin errors++; $display("FAIL hold_idle got %b want 00", {gnt0, busy}); end
    step();
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL hold_gnt_second got %b want 1", gnt0); end
    req0 = 1'b0;
    step();
    checks++; if (done0 !== 1'b1 || result_o !== 32'd30) begin errors++; $display("FAIL hold_done_second got %b/%0d want 1/30", done0, result_o); end
    step();
  endtask

  // Transaction model: pending requests, operand sets and the last granted requester.
  task automatic test_random();
    logic        pend [2];
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    logic [3:0]  pc [2];
    logic        last;
    int          w;
    logic [31:0] exp_res;
    apply_reset();
    last = 1'b1;
    for (int i = 0; i < 2; i++) begin pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; pc[i] = '0; end
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1; pa[i] = $urandom; pb[i] = $urandom; pc[i] = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 3) == 0) pb[i] = pa[i];
        end
      end
      if (!pend[0] && !pend[1]) begin
        w = $urandom_range(0, 1);
        pend[w] = 1'b1; pa[w] = $urandom; pb[w] = $urandom; pc[w] = ALUC_SUB;
      end
      req0 = pend[0]; a0 = pa[0]; b0 = pb[0]; aluc0 = pc[0];
      req1 = pend[1]; a1 = pa[1]; b1 = pb[1]; aluc1 = pc[1];
      if (pend[0] && pend[1]) w = (last == 1'b0) ? 1 : 0;
      else w = pend[1] ? 1 : 0;
      exp_res = ref_alu(pa[w], pb[w], pc[w]);
      step();
      checks++; if ({gnt1, gnt0} !== ((w == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rand_gnt op %0d got %b want winner %0d", n, {gnt1, gnt0}, w); end
      pend[w] = 1'b0; last = w[0];
      if (w == 1) req1 = 1'b0; else req0 = 1'b0;
      step();
      checks++; if ({done1, done0} !== ((w == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rand_done op %0d got %b want winner %0d", n, {done1, done0}, w); end
      checks++; if (result_o !== exp_res || zero_o !== (exp_res == 32'd0)) begin
        errors++; $display("FAIL rand_result op %0d aluc %h got %h/%b want %h/%b", n, pc[w], result_o, zero_o, exp_res, (exp_res == 32'd0));
      end
      step();
      checks++; if ({gnt0, gnt1, done0, done1, busy} !== 5'b0) begin errors++; $display("FAIL rand_idle op %0d got %b want 00000", n, {gnt0, gnt1, done0, done1, busy}); end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_simultaneous();
    test_round_robin();
    test_reset_exec();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority to requester 0.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, named clk and clrn.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 clrn  input  1  asynchronous active-low reset.
REQ-005 req0, req1  input  1 each  operation request; held high with operands stable until the matching gnt.
REQ-006 a0, b0, a1, b1  input  32 each  ALU operands per requester.
REQ-007 aluc0, aluc1  input  4 each  ALU opcode per requester, passed unmodified to the alu sub-module.
REQ-008 gnt0, gnt1  output  1 each  one-cycle pulse; the requester's operands were captured on the previous edge.
REQ-009 done0, done1  output  1 each  one-cycle pulse; result_o/zero_o are valid for that requester.
REQ-010 result_o  output  32  registered ALU result of the last completed operation.
REQ-011 zero_o  output  1  registered, 1 when result_o == 0.
REQ-012 busy  output  1  high in EXEC and RESP.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC and RESP, with transitions IDLE->EXEC on any sampled request, EXEC->RESP always, and RESP->IDLE always.
REQ-014 In IDLE with a request at the edge ending cycle T: capture a/b/aluc of the winner and record the owner; in T+1 (EXEC), pulse gnt of the owner; in T+2 (RESP), pulse done of the owner with result_o/zero_o updated at that edge.
REQ-015 Throughput SHALL be one operation per 3 cycles, and a request SHALL be sampled only in IDLE.
REQ-016 If RR_EN=1 and both requests are high, the requester not most recently granted SHALL win; a single request SHALL win regardless of the pointer.
REQ-017 If RR_EN=0 and both requests are high, requester 0 SHALL always win.
REQ-018 The round-robin pointer SHALL update only on grant.
REQ-019 At most one of gnt0/gnt1 and at most one of done0/done1 SHALL be high in any cycle.
REQ-020 result_o/zero_o SHALL hold their value between done pulses.
REQ-021 The ALU sub-module SHALL see only registered operands, and result_o SHALL be registered from its output in EXEC.
REQ-022 A requester still holding req when the FSM re-enters IDLE SHALL be treated as a new request.
REQ-023 Undefined aluc codes SHALL be passed through with no error flag.

Reset
REQ-024 While clrn=0, the FSM SHALL be in IDLE and gnt0/1, done0/1, busy, result_o and zero_o SHALL all be 0.
REQ-025 The round-robin pointer SHALL reset so that requester 0 wins the first contention.
REQ-026 Reset during EXEC or RESP SHALL abort the operation with no done pulse, and the first request after reset release SHALL be served normally.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the ALUC_ADD=4'b0000 and ALUC_SUB=4'b0100 constants, and the data width 32.
REQ-028 The existing alu module (a, b, aluc -> result, zero) SHALL be instantiated exactly once as the sole sub-module, with its zero output unused and zero_o derived from the registered result.
REQ-029 The arbitration and FSM logic SHALL be in this module.

Verification
REQ-030 Scenario: req0, a0=127, b0=128, aluc0=ALUC_ADD. Required response: gnt0 at T+1, done0 at T+2, result_o=255, zero_o=0, busy high for 2 cycles.
REQ-031 Scenario: req1, a1=128, b1=128, aluc1=ALUC_SUB. Required response: done1 at T+2, result_o=0, zero_o=1, no gnt0/done0 activity.
REQ-032 Scenario: after reset, req0 (1+1, ADD) and req1 (5-3, SUB) raised simultaneously and each dropped after its gnt. Required response: done0 with result 2, then done1 with result 2 exactly 3 cycles later.
REQ-033 Scenario: RR_EN=1 with both requests held continuously for 4 operations. Required response: grants alternate 0,1,0,1; with RR_EN=0 under the same stimulus, requester 0 SHALL receive all grants.
REQ-034 Scenario: clrn pulsed low during EXEC of 7+8. Required response: no done pulse, all outputs 0 immediately, then a subsequent req1 ADD 2+2 completes with result_o=4 and normal timing.
REQ-035 Scenario: req0 held high after its gnt. Required response: a second operation is granted at T+4 with identical result_o.
